residual_scale_add: RTL and testbench

- Residual junction at the end of each Inception-ResNet-B block. Its output is the 17x17x1088 stream that feeds the reduction stage.
- Computes out = shortcut + scale*branch in signed fixed point, with saturation and optional ReLU.
- Shortcut pixels arrive early and are buffered in an internal FIFO. Each one is consumed when the matching branch pixel arrives from the branch conv_11 (1x1 projection).
- Valid-only streaming: no backpressure, same as the neighbouring stages.

---
 rtl/residual_scale_add.sv | 108 ++++++++++
 tb/tb_residual_scale_add.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/residual_scale_add.sv
// residual_scale_add: shortcut + scale*branch with shortcut FIFO, saturation, optional ReLU (RESIDUAL_RELU_EN)
module residual_scale_add #(
  parameter int IMG_WIDTH  = 17,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int DEPTH      = 512,
  parameter int CHANNELS   = 1088
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_branch,
  input  logic [DATA_WIDTH-1:0] pxl_branch,
  input  logic [DATA_WIDTH-1:0] scale,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = IMG_WIDTH * IMG_WIDTH * CHANNELS;
  localparam int FW    = $clog2(FRAME);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int SW    = PW - FRAC_BITS + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp, rp;
  logic [AW:0]           cnt;
  logic                  full, empty, pop, push;
  logic signed [PW-1:0]  prod;
  logic                  unused_lsb;
  logic                  v1;
  logic [SW-2:0]         s1;
  logic [DATA_WIDTH-1:0] sc1;
  logic [SW-1:0]         sum;
  logic                  pos, neg;
  logic [DATA_WIDTH-1:0] sat, res;
  logic [FW-1:0]         fcnt;
  logic                  last;

  assign empty = cnt == '0;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign pop   = valid_branch && !empty;
  assign push  = valid_in && (!full || pop);

  assign prod = $signed({{DATA_WIDTH{pxl_branch[DATA_WIDTH-1]}}, pxl_branch})
              * $signed({{DATA_WIDTH{scale[DATA_WIDTH-1]}}, scale});
  assign unused_lsb = ^prod[FRAC_BITS-1:0];

  assign sum = {{(SW-DATA_WIDTH){sc1[DATA_WIDTH-1]}}, sc1} + {s1[SW-2], s1};
  assign pos = !sum[SW-1] && (|sum[SW-2:DATA_WIDTH-1]);
  assign neg = sum[SW-1] && !(&sum[SW-2:DATA_WIDTH-1]);
  assign sat = pos ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
               neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sum[DATA_WIDTH-1:0];
`ifdef RESIDUAL_RELU_EN
  assign res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign res = sat;
`endif
  assign last = fcnt == FW'(FRAME - 1);

  // shortcut storage, contents need no reset
  always_ff @(posedge clk)
    if (push) mem[wp] <= pxl_in;

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge clk)
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wp  <= wp + AW'(push);
      rp  <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (valid_in && full && !pop) overflow_err <= 1'b1;
      if (valid_branch && empty) underflow_err <= 1'b1;
    end

  // stage 1: scaled branch and matching shortcut head
  always_ff @(posedge clk) begin
    v1 <= !reset && pop;
    if (pop) begin
      s1  <= prod[PW-1:FRAC_BITS];
      sc1 <= mem[rp];
    end
  end

  // stage 2: saturated sum to output, frame position tracking
  always_ff @(posedge clk)
    if (reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      fcnt       <= '0;
    end else begin
      valid_out  <= v1;
      frame_done <= v1 && last;
      if (v1) begin
        pxl_out <= res;
        fcnt    <= last ? '0 : fcnt + FW'(1);
      end
    end
endmodule

// File: tb/tb_residual_scale_add.sv
// tb_residual_scale_add: scoreboard bench for residual_scale_add with DEPTH=4 and an 8-pixel frame
module tb_residual_scale_add;
  typedef struct {
    logic [31:0] d;
    logic        fd;
    int          due;
  } exp_t;

  logic        clk = 0, reset = 1, valid_in = 0, valid_branch = 0;
  logic [31:0] pxl_in = 0, pxl_branch = 0, scale = 0;
  logic [31:0] pxl_out;
  logic        valid_out, frame_done, overflow_err, underflow_err;
  int          cyc = 0, checks = 0, errors = 0, nout = 0;
  logic        ov = 0, un = 0;
  logic [31:0] last = 0;
  exp_t        exq[$];
  exp_t        mon_e;
  logic [31:0] scq[$];

  residual_scale_add #(.IMG_WIDTH(2), .DATA_WIDTH(32), .FRAC_BITS(16), .DEPTH(4), .CHANNELS(2)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .valid_branch(valid_branch), .pxl_branch(pxl_branch), .scale(scale),
    .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] sc, input logic [31:0] br, input logic [31:0] sl);
    longint p, s;
    p = longint'($signed(br)) * longint'($signed(sl));
    s = longint'($signed(sc)) + (p >>> 16);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef RESIDUAL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (exq.size() == 0) chk("unexpected_out", {31'b0, valid_out}, 32'd0);
      else begin
        mon_e = exq.pop_front();
        chk("pxl_out", pxl_out, mon_e.d);
        chk("frame_done", {31'b0, frame_done}, {31'b0, mon_e.fd});
        chk("latency", cyc, mon_e.due);
        last = pxl_out;
      end
    end else begin
      chk("hold", pxl_out, last);
      chk("fd_idle", {31'b0, frame_done}, 32'd0);
    end
  end

  task automatic step(input logic vi, input logic [31:0] pi, input logic vb, input logic [31:0] pb);
    logic pop_ok, fl;
    exp_t e;
    valid_in = vi; pxl_in = pi; valid_branch = vb; pxl_branch = pb;
    pop_ok = vb && scq.size() > 0;
    fl = scq.size() == 4;
    if (vb && !pop_ok) un = 1;
    if (vi && fl && !pop_ok) ov = 1;
    if (pop_ok) begin
      e.d = model(scq.pop_front(), pb, scale);
      e.fd = (nout % 8) == 7;
      e.due = cyc + 2;
      exq.push_back(e);
      nout++;
    end
    if (vi && (!fl || pop_ok)) scq.push_back(pi);
    @(posedge clk); #1;
    chk("overflow_err", {31'b0, overflow_err}, {31'b0, ov});
    chk("underflow_err", {31'b0, underflow_err}, {31'b0, un});
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic do_reset;
    reset = 1; valid_in = 0; valid_branch = 0;
    @(posedge clk); #1;
    reset = 0;
    exq.delete(); scq.delete();
    nout = 0; ov = 0; un = 0; last = 0;
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_pxl_out", pxl_out, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow_err}, 32'd0);
    chk("rst_underflow", {31'b0, underflow_err}, 32'd0);
  endtask

  task automatic pairs(input int n);
    step(1, $urandom, 0, 0);
    repeat (n - 1) step(1, $urandom, 1, $urandom);
    step(0, 0, 1, $urandom);
  endtask

  initial begin
    do_reset;
    scale = 32'h0000_8000;
    step(1, 32'h0001_0000, 0, 0);
    idle(2);
    step(0, 0, 1, 32'h0002_0000);
    idle(3);
    scale = 32'h0001_0000;
    step(1, 32'h7FFF_0000, 0, 0);
    step(0, 0, 1, 32'h7FFF_0000);
    step(1, 32'h8001_0000, 0, 0);
    step(0, 0, 1, 32'h8001_0000);
    idle(3);
    scale = 32'h0000_2B85;
    step(1, 32'hFFFF_0000, 0, 0);
    step(0, 0, 1, 0);
    idle(3);
    do_reset;
    scale = 32'h0001_0000;
    for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    idle(3);
    do_reset;
    for (int i = 0; i < 4; i++) step(1, 10 + i, 0, 0);
    step(1, 14, 1, 0);
    step(1, 15, 0, 0);
    repeat (4) step(0, 0, 1, 0);
    idle(3);
    do_reset;
    scale = $urandom_range(0, 32'h0002_0000);
    pairs(10);
    idle(3);
    do_reset;
    scale = $urandom;
    step(1, $urandom, 0, 0);
    repeat (3) step(1, $urandom, 1, $urandom);
    do_reset;
    scale = 32'hFFFF_4000;
    pairs(8);
    idle(3);
    chk("drained", exq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
